// File: rtl/q_frag_timing_mon_if.sv
// Pin bundle between an instrumented Q_FRAG flop and its timing monitor:
// observed flop pins in, notifier and violation report out.
interface q_frag_timing_mon_if #(
  parameter int CNT_W = 8
);
  logic             QCK;
  logic             QDI;
  logic             QEN;
  logic             QST;
  logic             QRT;
  logic             NOTIFIER;
  logic             VIOL_VLD;
  logic [1:0]       VIOL_TYPE;
  logic [CNT_W-1:0] VIOL_CNT;

  modport master (
    output QCK, QDI, QEN, QST, QRT,
    input  NOTIFIER, VIOL_VLD, VIOL_TYPE, VIOL_CNT
  );

  modport slave (
    input  QCK, QDI, QEN, QST, QRT,
    output NOTIFIER, VIOL_VLD, VIOL_TYPE, VIOL_CNT
  );
endinterface

// File: rtl/q_frag_timing_mon.sv
// Oversampling setup/hold/recovery monitor driving a Q_FRAG notifier.
// Define Q_FRAG_MON_RECOVERY_EN to compile in the recovery age counter and check.
module q_frag_timing_mon #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int REC_CYC   = 2,
  parameter int CNT_W     = 8
) (
  input  logic               CK,
  input  logic               RST,
  q_frag_timing_mon_if.slave mon
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} holdState_t;

  localparam logic [7:0]       AGE_MAX    = 8'hFF;
  localparam logic [7:0]       SETUP_LIM  = 8'(SETUP_CYC);
  localparam logic [7:0]       HOLD_LIM   = 8'(HOLD_CYC);
  localparam logic [1:0]       TYPE_SETUP = 2'b01;
  localparam logic [1:0]       TYPE_REC   = 2'b10;
  localparam logic [1:0]       TYPE_HOLD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic             sQck_q, pQck_q, sQdi_q, pQdi_q, sQen_q;
  logic             qckRise, qdiChange, qualRise;
  logic             setupViol, recViol, holdViol, anyViol;
  logic [1:0]       violType;
  logic [7:0]       dataAge_q, dataAge_d;
  logic [7:0]       window_q, window_d;
  holdState_t       state_q, state_d;
  logic             notifier_q, notifier_d;
  logic             vld_q;
  logic [1:0]       type_q, type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sampling continues through reset so a steady pin never looks like an edge afterwards.
  always_ff @(posedge CK) begin
    sQck_q <= mon.QCK;
    pQck_q <= sQck_q;
    sQdi_q <= mon.QDI;
    pQdi_q <= sQdi_q;
    sQen_q <= mon.QEN;
  end

  assign qckRise   = sQck_q & ~pQck_q;
  assign qdiChange = sQdi_q ^ pQdi_q;
  assign qualRise  = qckRise & sQen_q;

  always_comb begin
    dataAge_d = dataAge_q;
    if (qdiChange) begin
      dataAge_d = 8'd0;
    end else if (dataAge_q != AGE_MAX) begin
      dataAge_d = dataAge_q + 8'd1;
    end
  end

  assign setupViol = qualRise & (qdiChange | (dataAge_q < SETUP_LIM));

`ifdef Q_FRAG_MON_RECOVERY_EN
  localparam logic [7:0] REC_LIM = 8'(REC_CYC);

  logic       sQst_q, pQst_q, sQrt_q, pQrt_q;
  logic       recFall;
  logic [7:0] recAge_q, recAge_d;

  always_ff @(posedge CK) begin
    sQst_q <= mon.QST;
    pQst_q <= sQst_q;
    sQrt_q <= mon.QRT;
    pQrt_q <= sQrt_q;
  end

  assign recFall = (pQst_q & ~sQst_q) | (pQrt_q & ~sQrt_q);

  always_comb begin
    recAge_d = recAge_q;
    if (recFall) begin
      recAge_d = 8'd0;
    end else if (recAge_q != AGE_MAX) begin
      recAge_d = recAge_q + 8'd1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      recAge_q <= AGE_MAX;
    end else begin
      recAge_q <= recAge_d;
    end
  end

  // Recovery applies to every clock edge; the enable cannot mask an async release.
  assign recViol = qckRise & (recAge_q < REC_LIM);
`else
  localparam logic [7:0] unusedRecLim = 8'(REC_CYC);
  logic unusedRecPins;
  assign unusedRecPins = mon.QST ^ mon.QRT;
  assign recViol       = 1'b0;
`endif

  // A change coinciding with a qualifying edge belongs to the setup check, never hold.
  assign holdViol = (state_q == HOLD) & qdiChange & ~qualRise;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (qualRise) begin
          state_d  = HOLD;
          window_d = HOLD_LIM;
        end
      end
      HOLD: begin
        if (qualRise) begin
          window_d = HOLD_LIM;
        end else if (qdiChange) begin
          state_d  = IDLE;
          window_d = 8'd0;
        end else if (window_q <= 8'd1) begin
          state_d  = IDLE;
          window_d = 8'd0;
        end else begin
          window_d = window_q - 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        window_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    anyViol  = setupViol | recViol | holdViol;
    violType = TYPE_HOLD;
    if (setupViol) begin
      violType = TYPE_SETUP;
    end else if (recViol) begin
      violType = TYPE_REC;
    end
    notifier_d = notifier_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    if (anyViol) begin
      notifier_d = ~notifier_q;
      type_d     = violType;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold FSM and the report registers share one reset so a mid-window reset reports nothing.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= IDLE;
      window_q   <= 8'd0;
      dataAge_q  <= AGE_MAX;
      notifier_q <= 1'b0;
      vld_q      <= 1'b0;
      type_q     <= 2'b00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      dataAge_q  <= dataAge_d;
      notifier_q <= notifier_d;
      vld_q      <= anyViol;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mon.NOTIFIER  = notifier_q;
  assign mon.VIOL_VLD  = vld_q;
  assign mon.VIOL_TYPE = type_q;
  assign mon.VIOL_CNT  = cnt_q;
endmodule

// File: tb/tb_q_frag_timing_mon.sv
// Self-checking bench for q_frag_timing_mon: directed pin sequences, a sample-history
// model checked every cycle, and literal checkpoints; a CNT_W=2 copy covers saturation.
module tb_q_frag_timing_mon;
  localparam int SETUP_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int REC_CYC   = 2;
  localparam int HMAX      = 4096;

  logic CK;
  logic rst;
  logic qck, qdi, qen, qst, qrt;

  int nCompared = 0;
  int nMismatch = 0;

  q_frag_timing_mon_if #(.CNT_W(8)) ifA ();
  q_frag_timing_mon_if #(.CNT_W(2)) ifB ();

  assign ifA.QCK = qck;
  assign ifA.QDI = qdi;
  assign ifA.QEN = qen;
  assign ifA.QST = qst;
  assign ifA.QRT = qrt;
  assign ifB.QCK = qck;
  assign ifB.QDI = qdi;
  assign ifB.QEN = qen;
  assign ifB.QST = qst;
  assign ifB.QRT = qrt;

  q_frag_timing_mon #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .REC_CYC(REC_CYC), .CNT_W(8))
    dutA (.CK(CK), .RST(rst), .mon(ifA));
  q_frag_timing_mon #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .REC_CYC(REC_CYC), .CNT_W(2))
    dutB (.CK(CK), .RST(rst), .mon(ifB));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic checkOutput(input string name, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Pin history indexed by CK edge; sample n is what the monitor saw at edge n.
  logic qckH[HMAX], qdiH[HMAX], qenH[HMAX], qstH[HMAX], qrtH[HMAX];
  int   edgeIdx = -1;
  int   lastRst = 0;
  int   repCount = 0;
  int   expNotif = 0;
  int   expVld = 0;
  int   expType = 0;

  function automatic bit chgAt(int m);
    return (m >= 1) && (qdiH[m] != qdiH[m-1]);
  endfunction

  function automatic bit riseAt(int m);
    return (m >= 1) && qckH[m] && !qckH[m-1];
  endfunction

`ifdef Q_FRAG_MON_RECOVERY_EN
  function automatic bit fallAt(int m);
    return (m >= 1) && ((qstH[m-1] && !qstH[m]) || (qrtH[m-1] && !qrtH[m]));
  endfunction
`endif

  // Decide from the pin history which violation (if any) sample n must report.
  task automatic evalSample(input int n);
    bit su, rc, hd;
    int r;
    su = 0; rc = 0; hd = 0;
    if (n >= 1) begin
      if (riseAt(n) && qenH[n]) begin
        for (int m = n; m >= n - SETUP_CYC && m >= lastRst; m--)
          if (chgAt(m)) su = 1;
      end
`ifdef Q_FRAG_MON_RECOVERY_EN
      if (riseAt(n)) begin
        for (int m = n - 1; m >= n - REC_CYC && m >= lastRst; m--)
          if (fallAt(m)) rc = 1;
      end
`endif
      if (chgAt(n) && !(riseAt(n) && qenH[n])) begin
        r = -1;
        for (int m = n - 1; m >= lastRst && m >= 1 && r < 0; m--)
          if (riseAt(m) && qenH[m]) r = m;
        if (r >= 0 && (n - r) <= HOLD_CYC) begin
          hd = 1;
          for (int m = r + 1; m < n; m++)
            if (chgAt(m)) hd = 0;
        end
      end
    end
    expVld = (su || rc || hd) ? 1 : 0;
    if (expVld == 1) begin
      repCount++;
      expNotif = 1 - expNotif;
      expType  = su ? 1 : (rc ? 2 : 3);
    end
  endtask

  // Model update at each CK edge, comparison a little later while outputs are stable.
  always @(posedge CK) begin
    edgeIdx++;
    if (edgeIdx < HMAX) begin
      qckH[edgeIdx] = qck;
      qdiH[edgeIdx] = qdi;
      qenH[edgeIdx] = qen;
      qstH[edgeIdx] = qst;
      qrtH[edgeIdx] = qrt;
      if (rst) begin
        lastRst  = edgeIdx;
        repCount = 0;
        expNotif = 0;
        expVld   = 0;
        expType  = 0;
      end else begin
        evalSample(edgeIdx - 1);
      end
      #2;
      checkOutput("cyc_notifA", int'(ifA.NOTIFIER), expNotif);
      checkOutput("cyc_vldA", int'(ifA.VIOL_VLD), expVld);
      checkOutput("cyc_typeA", int'(ifA.VIOL_TYPE), expType);
      checkOutput("cyc_cntA", int'(ifA.VIOL_CNT), (repCount > 255) ? 255 : repCount);
      checkOutput("cyc_notifB", int'(ifB.NOTIFIER), expNotif);
      checkOutput("cyc_vldB", int'(ifB.VIOL_VLD), expVld);
      checkOutput("cyc_cntB", int'(ifB.VIOL_CNT), (repCount > 3) ? 3 : repCount);
    end
  end

  task automatic applyStimulus(input logic ck, input logic d, input logic en,
                               input logic st, input logic rt, input logic r);
    @(negedge CK);
    qck = ck;
    qdi = d;
    qen = en;
    qst = st;
    qrt = rt;
    rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(qck, qdi, qen, qst, qrt, rst);
  endtask

  initial begin
    qck = 0; qdi = 0; qen = 1; qst = 0; qrt = 0; rst = 1;
    idle(4);
    checkOutput("rst_notif", int'(ifA.NOTIFIER), 0);
    checkOutput("rst_vld", int'(ifA.VIOL_VLD), 0);
    checkOutput("rst_type", int'(ifA.VIOL_TYPE), 0);
    checkOutput("rst_cnt", int'(ifA.VIOL_CNT), 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    idle(3);

    // Data settled 5 samples before the edge and held after it: clean.
    applyStimulus(0, ~qdi, 1, 0, 0, 0);
    idle(4);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    idle(3);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);
    checkOutput("clean_cnt", int'(ifA.VIOL_CNT), 0);
    checkOutput("clean_notif", int'(ifA.NOTIFIER), 0);

    // Data one sample before the edge: setup, reported two CK after the edge.
    applyStimulus(0, ~qdi, 1, 0, 0, 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    checkOutput("setup_vld_early", int'(ifA.VIOL_VLD), 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    checkOutput("setup_vld", int'(ifA.VIOL_VLD), 1);
    checkOutput("setup_type", int'(ifA.VIOL_TYPE), 1);
    checkOutput("setup_cnt", int'(ifA.VIOL_CNT), 1);
    checkOutput("setup_notif", int'(ifA.NOTIFIER), 1);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    checkOutput("setup_vld_end", int'(ifA.VIOL_VLD), 0);
    idle(3);

    // Same timing with the enable low: no report.
    applyStimulus(0, ~qdi, 0, 0, 0, 0);
    applyStimulus(1, qdi, 0, 0, 0, 0);
    idle(3);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);
    checkOutput("noen_cnt", int'(ifA.VIOL_CNT), 1);

    applyStimulus(0, qdi, 1, 0, 0, 1);
    idle(1);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);
    checkOutput("rst2_cnt", int'(ifA.VIOL_CNT), 0);

    // Data change in the sample after a qualifying edge: hold, twice.
    applyStimulus(1, qdi, 1, 0, 0, 0);
    applyStimulus(1, ~qdi, 1, 0, 0, 0);
    idle(2);
    checkOutput("hold1_type", int'(ifA.VIOL_TYPE), 3);
    checkOutput("hold1_cnt", int'(ifA.VIOL_CNT), 1);
    checkOutput("hold1_notif", int'(ifA.NOTIFIER), 1);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(4);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    applyStimulus(1, ~qdi, 1, 0, 0, 0);
    idle(2);
    checkOutput("hold2_type", int'(ifA.VIOL_TYPE), 3);
    checkOutput("hold2_cnt", int'(ifA.VIOL_CNT), 2);
    checkOutput("hold2_notif", int'(ifA.NOTIFIER), 0);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(4);

    // Async reset released one sample before the edge.
    applyStimulus(0, qdi, 1, 0, 1, 0);
    idle(2);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    idle(3);
`ifdef Q_FRAG_MON_RECOVERY_EN
    checkOutput("rec_type", int'(ifA.VIOL_TYPE), 2);
    checkOutput("rec_cnt", int'(ifA.VIOL_CNT), 3);
`else
    checkOutput("rec_type", int'(ifA.VIOL_TYPE), 3);
    checkOutput("rec_cnt", int'(ifA.VIOL_CNT), 2);
`endif
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);

    // Data change, reset release and edge in one sample: a single setup report.
    applyStimulus(0, qdi, 1, 0, 1, 0);
    idle(3);
    applyStimulus(1, ~qdi, 1, 0, 0, 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    checkOutput("simul_vld_early", int'(ifA.VIOL_VLD), 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    checkOutput("simul_vld", int'(ifA.VIOL_VLD), 1);
    checkOutput("simul_type", int'(ifA.VIOL_TYPE), 1);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    checkOutput("simul_vld_once", int'(ifA.VIOL_VLD), 0);
`ifdef Q_FRAG_MON_RECOVERY_EN
    checkOutput("simul_cnt", int'(ifA.VIOL_CNT), 4);
`else
    checkOutput("simul_cnt", int'(ifA.VIOL_CNT), 3);
`endif
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);

    // Five setup violations after a reset: the 2-bit counter sticks at 3.
    applyStimulus(0, qdi, 1, 0, 0, 1);
    idle(1);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, ~qdi, 1, 0, 0, 0);
      applyStimulus(1, qdi, 1, 0, 0, 0);
      applyStimulus(1, qdi, 1, 0, 0, 0);
      applyStimulus(0, qdi, 1, 0, 0, 0);
    end
    idle(3);
    checkOutput("sat_cntA", int'(ifA.VIOL_CNT), 5);
    checkOutput("sat_cntB", int'(ifB.VIOL_CNT), 3);
    checkOutput("sat_notif", int'(ifA.NOTIFIER), 1);

    // Setup then hold on consecutive samples: two back-to-back reports.
    applyStimulus(0, ~qdi, 1, 0, 0, 0);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    applyStimulus(1, ~qdi, 1, 0, 0, 0);
    idle(3);
    checkOutput("b2b_cntA", int'(ifA.VIOL_CNT), 7);
    checkOutput("b2b_type", int'(ifA.VIOL_TYPE), 3);
    checkOutput("b2b_notif", int'(ifA.NOTIFIER), 1);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(3);

    // Reset lands inside an open hold window together with a data change.
    applyStimulus(1, qdi, 1, 0, 0, 0);
    applyStimulus(1, ~qdi, 1, 0, 0, 1);
    applyStimulus(1, qdi, 1, 0, 0, 0);
    idle(3);
    checkOutput("abort_notif", int'(ifA.NOTIFIER), 0);
    checkOutput("abort_vld", int'(ifA.VIOL_VLD), 0);
    checkOutput("abort_type", int'(ifA.VIOL_TYPE), 0);
    checkOutput("abort_cntA", int'(ifA.VIOL_CNT), 0);
    checkOutput("abort_cntB", int'(ifB.VIOL_CNT), 0);
    applyStimulus(0, qdi, 1, 0, 0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule

// File: doc/q_frag_timing_mon.md
# q_frag_timing_mon

Cycle-based setup/hold/recovery monitor that drives the `notifier` input of a `Q_FRAG` flip-flop model in simulation and emulation netlists. It oversamples the flop's clock, data, enable and async set/reset pins on a fast monitor clock and flags window violations. It toggles `NOTIFIER` once per violation, so the flop's `@(notifier)` sensitivity fires. It sits beside each instrumented `Q_FRAG`, driven from the same nets.

## Interface
- `SETUP_CYC`, 2: minimum CK samples QDI must be stable before a QCK rise (1..255)
- `HOLD_CYC`, 1: CK samples after a QCK rise during which QDI must not change (1..255)
- `REC_CYC`, 2: minimum CK samples between QST/QRT deassertion and a QCK rise (1..255)
- `CNT_W`, 8: width of the violation counter
- `CK`  input  1  monitor sample clock; every observed pin is sampled on its rising edge
- `RST`  input  1  synchronous, active-high reset
- `QCK`  input  1  observed flop clock
- `QDI`  input  1  observed flop data
- `QEN`  input  1  observed flop enable
- `QST`  input  1  observed flop set (muxed value, active-high)
- `QRT`  input  1  observed flop reset (muxed value, active-high)
- `NOTIFIER`  output  1  toggles once per reported violation
- `VIOL_VLD`  output  1  one-CK pulse per reported violation
- `VIOL_TYPE`  output  2  type of the last reported violation: 01 setup, 10 recovery, 11 hold
- `VIOL_CNT`  output  CNT_W  count of reported violations, saturating

## Operation
- Input stage: QCK/QDI/QEN/QST/QRT are registered once on CK (s_*), with a second register (p_*) for edge detection. A QCK rise is `s_qck & ~p_qck`. A QDI change is `s_qdi ^ p_qdi`.
- Data age counter: 8 bits. Clears to 0 on a QDI change, otherwise increments and saturates at 255.
- Recovery age counter: 8 bits. Clears to 0 on a 1→0 transition of QST or QRT, otherwise increments and saturates at 255.
- Setup check: a QCK rise with s_qen=1 and data age < SETUP_CYC is a setup violation. A QDI change in the same sample as the QCK rise counts as age 0, so it is a setup violation.
- Hold FSM:
  - IDLE: a QCK rise with s_qen=1 loads the window counter with HOLD_CYC and moves to HOLD.
  - HOLD: a QDI change is a hold violation and returns to IDLE.
  - HOLD: on each sample with no QDI change the window counter decrements; at 0 the FSM returns to IDLE.
  - HOLD: a new qualifying QCK rise reloads the window counter.
  - A QDI change in the same sample as a QCK rise is the setup case, not hold.
- Recovery check: a QCK rise, regardless of QEN, with recovery age < REC_CYC is a recovery violation.
- Priority: at most one violation is reported per sample, in the order setup > recovery > hold. The lower-priority events in that sample are dropped.
- Report: on each reported violation,
  - NOTIFIER inverts;
  - VIOL_VLD=1 for one CK;
  - VIOL_TYPE is updated;
  - VIOL_CNT increments, saturating at 2^CNT_W−1.
- Reset values: NOTIFIER=0, VIOL_VLD=0, VIOL_TYPE=00, VIOL_CNT=0, FSM=IDLE, both age counters=255.
- The s_* and p_* registers keep sampling while RST=1, so a pin held steady through reset produces no spurious edge. A reset asserted mid-window aborts the window with no report.

## Timing
- Pin change to s_* register: 1 CK. Detection is combinational on s_*/p_*. Report registers update on the next CK, so pin edge to NOTIFIER/VIOL_VLD is 2 CK.
- Back-to-back violations on consecutive samples produce consecutive VIOL_VLD pulses and two NOTIFIER toggles.
- Window arithmetic is in whole CK samples. Any QCK/QDI edge closer together than one CK period is unresolvable and is treated as simultaneous.

## Configuration
- `Q_FRAG_MON_RECOVERY_EN` defined: the recovery age counter and recovery check are compiled in.
- `Q_FRAG_MON_RECOVERY_EN` undefined:
  - QST/QRT are still ports but are ignored;
  - the recovery counter is removed;
  - VIOL_TYPE=10 is never produced;
  - setup/hold behaviour is unchanged.

## Test plan
- Defaults. QDI toggles 5 CK before a QCK rise with QEN=1, no QDI change for 3 CK after → no VIOL_VLD, VIOL_CNT=0, NOTIFIER=0.
- QDI toggles 1 CK before a QCK rise, QEN=1 → VIOL_VLD pulse 2 CK after the QCK rise, VIOL_TYPE=01, VIOL_CNT=1, NOTIFIER=1. Repeat with QEN=0 → no report.
- QCK rise, QEN=1, QDI toggles in the next sample (HOLD_CYC=1) → VIOL_TYPE=11. A second identical event → VIOL_CNT=2, NOTIFIER back to 0.
- With the macro defined, QRT falls 1 CK before a QCK rise → VIOL_TYPE=10. Without the macro → no report.
- QDI change, QRT fall and QCK rise all in the same sample → exactly one report, VIOL_TYPE=01.
- CNT_W=2: five setup violations → VIOL_CNT saturates at 3, NOTIFIER toggles 5 times. RST asserted during an open hold window, then QDI toggled → no report, all outputs at reset values.
